// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM read-side streaming controller.
//   BRAM_ADDR_W / BRAM_DATA_W : geometry of the 256 x 128 activation/weight BRAM
//   state_e                   : controller states
package bram_stream_reader_pkg;

  localparam int unsigned BRAM_ADDR_W = 8;
  localparam int unsigned BRAM_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// stream_fifo: small synchronous FIFO with occupancy count.
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_data   : write strobe and entry
//   pop, pop_data     : read strobe and head entry (valid while !empty)
//   count, empty      : occupancy
// Pushing while full and popping while empty are ignored; the head entry is
// held stable until it is popped.
module stream_fifo #(
  parameter  int unsigned WIDTH = 129,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (32'(count_q) < DEPTH);
    do_pop   = pop && (count_q != '0);

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a burst of words from one BRAM port and presents
// them as a valid/ready stream with a last-beat flag.
//   clk, reset                      : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_addr, cmd_size              : first address, beat count minus one
//   bram_en/bram_we/bram_addr       : BRAM port (read-only, we tied low)
//   bram_dout                       : BRAM registered read data
//   out_valid/out_ready             : output stream handshake
//   out_data, out_last              : beat payload, final-beat flag
//   busy                            : command in progress
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = BRAM_ADDR_W,
  parameter int unsigned DATA_W     = BRAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_size,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;

  logic              issue;
  logic              can_issue;
  logic              last_issue;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_rdata;

  // Read pipeline: the issue cycle presents the address (stage 1); rd_vld_q
  // marks the following cycle, in which bram_dout holds that word (stage 2)
  // and is pushed at the next edge. rd_vld_q is therefore the in-flight read
  // count that the credit check has to reserve FIFO space for.
  assign can_issue  = (32'(fifo_count) + 32'(rd_vld_q)) < FIFO_DEPTH;
  assign last_issue = (cnt_q == size_q);
  assign pop        = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    cmd_ready = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          size_d  = cmd_size;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (can_issue) begin
          issue = 1'b1;
          if (last_issue) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_vld_d  = issue;
    rd_last_d = issue && last_issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign bram_en   = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = issue ? (addr_q + cnt_q) : '0;
  assign busy      = (state_q != IDLE);

  stream_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_vld_q),
    .push_data ({rd_last_q, bram_dout}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign out_last  = fifo_rdata[DATA_W];

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_size;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [256];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] exp_addr_q [$];

  bram_stream_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Registered-output BRAM: holds its output while disabled.
  always @(posedge clk) begin
    if (bram_en === 1'b1) bram_dout <= mem[bram_addr];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queues the expected addresses/beats, then offers the command for one edge.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] s, output logic acc_rdy);
    logic [AW-1:0] ad;
    for (int i = 0; i <= int'(s); i++) begin
      ad = a + AW'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back({(i == int'(s)), mem[ad]});
    end
    @(negedge clk);
    cmd_addr  = a;
    cmd_size  = s;
    cmd_valid = 1'b1;
    acc_rdy   = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Advance to the middle of the next cycle and set out_ready for its closing edge.
  task automatic tick(input logic rdy);
    @(negedge clk);
    out_ready = rdy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL reset_ctrl: got {cmd_ready,busy}=%b expected 10", {cmd_ready, busy});
    end
    n_cmp++;
    if ({bram_en, bram_we, bram_addr} !== 10'h000) begin
      n_bad++; $display("FAIL reset_bram: got {en,we,addr}=%h expected 000", {bram_en, bram_we, bram_addr});
    end
    n_cmp++;
    if ({out_valid, out_last, out_data} !== {(DW+2){1'b0}}) begin
      n_bad++; $display("FAIL reset_out: got valid=%b last=%b data=%h expected all zero", out_valid, out_last, out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic acc;
    int en_cnt = 0;
    int hs_cyc = -1;
    logic [AW-1:0] ea;
    logic [DW:0] eb;
    send_cmd(8'h10, 8'h00, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL single_cmd_ready: got %b expected 1", acc); end
    for (int c = 1; c <= 6; c++) begin
      tick(1'b1);
      if (bram_en === 1'b1) begin
        en_cnt++;
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL single_extra_issue: got addr %h expected no issue", bram_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bram_addr !== ea) begin n_bad++; $display("FAIL single_addr: got %h expected %h", bram_addr, ea); end
        end
      end
      if (out_valid === 1'b1) begin
        hs_cyc = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL single_extra_beat: got %h expected none", {out_last, out_data});
        end else begin
          eb = exp_q.pop_front();
          if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL single_beat: got %h expected %h", {out_last, out_data}, eb); end
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
      end
    end
    n_cmp++;
    if (en_cnt != 1) begin n_bad++; $display("FAIL single_en_pulses: got %0d expected 1", en_cnt); end
    n_cmp++;
    if (hs_cyc != 3) begin n_bad++; $display("FAIL single_latency: got cycle %0d expected 3", hs_cyc); end
  endtask

  task automatic test_burst(input logic [AW-1:0] a, input logic [AW-1:0] s, input string tag);
    logic acc;
    int n = int'(s) + 1;
    int first_hs = -1;
    int last_hs = -1;
    int beats = 0;
    logic [AW-1:0] ea;
    logic [DW:0] eb;
    send_cmd(a, s, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL %s_cmd_ready: got %b expected 1", tag, acc); end
    for (int c = 1; c <= n + 5; c++) begin
      tick(1'b1);
      if (bram_en === 1'b1) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL %s_extra_issue: got addr %h expected no issue", tag, bram_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bram_addr !== ea) begin n_bad++; $display("FAIL %s_addr: got %h expected %h", tag, bram_addr, ea); end
        end
      end
      if (out_valid === 1'b1) begin
        beats++;
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL %s_extra_beat: got %h expected none", tag, {out_last, out_data});
        end else begin
          eb = exp_q.pop_front();
          if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL %s_beat%0d: got %h expected %h", tag, beats, {out_last, out_data}, eb); end
        end
      end
      if (c == n + 3) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_fall: got %b expected 0", tag, busy); end
      end
    end
    n_cmp++;
    if (beats != n) begin n_bad++; $display("FAIL %s_beat_count: got %0d expected %0d", tag, beats, n); end
    n_cmp++;
    if (first_hs != 3 || last_hs != n + 2) begin
      n_bad++; $display("FAIL %s_timing: got first=%0d last=%0d expected first=3 last=%0d", tag, first_hs, last_hs, n + 2);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int issued = 0;
    int popped = 0;
    int outstanding;
    logic exp_en;
    logic prev_stall = 1'b0;
    logic [DW:0] prev_beat = '0;
    logic [AW-1:0] ea;
    logic [DW:0] eb;
    send_cmd(8'h30, 8'd15, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL bp_cmd_ready: got %b expected 1", acc); end
    for (int c = 1; c <= 300 && popped < 16; c++) begin
      tick((c <= 8) ? 1'b0 : 1'($urandom_range(0, 1)));
      outstanding = issued - popped;
      n_cmp++;
      if (outstanding > FD) begin n_bad++; $display("FAIL bp_occupancy: got %0d expected <= %0d", outstanding, FD); end
      exp_en = (issued < 16) && (outstanding < FD);
      n_cmp++;
      if (bram_en !== exp_en) begin n_bad++; $display("FAIL bp_credit: cycle %0d got en=%b expected %b", c, bram_en, exp_en); end
      if (bram_en === 1'b1 && exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        issued++;
        n_cmp++;
        if (bram_addr !== ea) begin n_bad++; $display("FAIL bp_addr: got %h expected %h", bram_addr, ea); end
      end
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid, out_last, out_data} !== {1'b1, prev_beat}) begin
          n_bad++; $display("FAIL bp_hold: got valid=%b beat=%h expected valid=1 beat=%h", out_valid, {out_last, out_data}, prev_beat);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_beat: got %h expected none", {out_last, out_data});
        end else begin
          eb = exp_q.pop_front();
          popped++;
          if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL bp_beat%0d: got %h expected %h", popped, {out_last, out_data}, eb); end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_beat  = {out_last, out_data};
    end
    n_cmp++;
    if (popped != 16) begin n_bad++; $display("FAIL bp_complete: got %0d beats expected 16", popped); end
    tick(1'b1);
    tick(1'b1);
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL bp_idle: got {busy,valid}=%b expected 00", {busy, out_valid}); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int popped = 0;
    int beats = 0;
    logic [DW:0] eb;
    send_cmd(8'h80, 8'd31, acc);
    for (int c = 1; c <= 40 && popped < 5; c++) begin
      tick(1'b1);
      if (out_valid === 1'b1) begin
        eb = exp_q.pop_front();
        popped++;
        n_cmp++;
        if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL rm_pre_beat%0d: got %h expected %h", popped, {out_last, out_data}, eb); end
      end
    end
    tick(1'b1);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, cmd_ready, busy, bram_en} !== 4'b0100) begin
      n_bad++; $display("FAIL rm_reset_now: got {valid,cmd_ready,busy,en}=%b expected 0100", {out_valid, cmd_ready, busy, bram_en});
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    send_cmd(8'h40, 8'd1, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL rm_cmd_ready: got %b expected 1", acc); end
    for (int c = 1; c <= 10; c++) begin
      tick(1'b1);
      if (out_valid === 1'b1) begin
        beats++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rm_extra_beat: got %h expected none", {out_last, out_data});
        end else begin
          eb = exp_q.pop_front();
          if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL rm_post_beat%0d: got %h expected %h", beats, {out_last, out_data}, eb); end
        end
      end
    end
    n_cmp++;
    if (beats != 2) begin n_bad++; $display("FAIL rm_post_count: got %0d expected 2", beats); end
    exp_addr_q.delete();
  endtask

  task automatic test_full_depth();
    logic acc;
    int beats = 0;
    int last_hs = -1;
    logic [AW-1:0] ea;
    logic [DW:0] eb;
    send_cmd(8'h00, 8'hFF, acc);
    n_cmp++;
    if (acc !== 1'b1) begin n_bad++; $display("FAIL full_cmd_ready: got %b expected 1", acc); end
    for (int c = 1; c <= 400 && beats < 256; c++) begin
      tick(1'b1);
      if (c >= 5 && c <= 20) begin
        cmd_valid = 1'b1;
        cmd_addr  = 8'h99;
        cmd_size  = 8'h00;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_cmd_ready_busy: got %b expected 0", cmd_ready); end
      end else begin
        cmd_valid = 1'b0;
      end
      n_cmp++;
      if (bram_we !== 1'b0) begin n_bad++; $display("FAIL full_we: got %b expected 0", bram_we); end
      if (bram_en === 1'b1) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_bad++; $display("FAIL full_extra_issue: got addr %h expected no issue", bram_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bram_addr !== ea) begin n_bad++; $display("FAIL full_addr: got %h expected %h", bram_addr, ea); end
        end
      end
      if (out_valid === 1'b1) begin
        beats++;
        last_hs = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL full_extra_beat: got %h expected none", {out_last, out_data});
        end else begin
          eb = exp_q.pop_front();
          if ({out_last, out_data} !== eb) begin n_bad++; $display("FAIL full_beat%0d: got %h expected %h", beats, {out_last, out_data}, eb); end
        end
      end
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (beats != 256 || last_hs != 258) begin
      n_bad++; $display("FAIL full_count: got beats=%0d last=%0d expected beats=256 last=258", beats, last_hs);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1);
      n_cmp++;
      if ({busy, out_valid, bram_en} !== 3'b000) begin
        n_bad++; $display("FAIL full_ignored_cmd: got {busy,valid,en}=%b expected 000", {busy, out_valid, bram_en});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(i)};
    end
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    out_ready = 1'b0;

    test_reset();
    test_single();
    test_burst(8'h20, 8'd7, "burst");
    test_burst(8'hFE, 8'd3, "wrap");
    test_backpressure();
    test_reset_mid();
    test_full_depth();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side streaming controller for the dual-port 128×256 activation/weight BRAM. It accepts a command (start address, beat count), drives one BRAM port in read-only mode, and absorbs the BRAM's registered-output latency. It presents the words as a valid/ready stream with a last-beat flag and a small credit-controlled FIFO, so downstream back-pressure never drops data. It sits between the BRAM port and the systolic-array/DMA data path.

## Interface
- `ADDR_W`, 8: BRAM address width; depth is 2^ADDR_W.
- `DATA_W`, 128: BRAM word width.
- `FIFO_DEPTH`, 4: output FIFO entries; must be ≥3 for full rate.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both are high.
- `cmd_addr`  in  ADDR_W  first BRAM address.
- `cmd_size`  in  ADDR_W  beat count minus one (0 → 1 beat, 255 → 256 beats).
- `bram_en`  out  1  BRAM port enable.
- `bram_we`  out  1  BRAM write enable; constant 0.
- `bram_addr`  out  ADDR_W  BRAM address.
- `bram_dout`  in  DATA_W  BRAM registered read data.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  beat payload.
- `out_last`  out  1  final beat of the command.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
  - IDLE: `cmd_ready`=1. On handshake, latch addr and size, clear the issue counter, and go to ISSUE.
  - ISSUE: a read is issued in any cycle where `fifo_count + pending < FIFO_DEPTH`. On issue, `bram_en`=1 and `bram_addr`=latched addr + issue count, mod 2^ADDR_W.
  - ISSUE → DRAIN in the cycle the read with issue count = size is issued.
  - DRAIN → IDLE on the handshake of the beat with `out_last`=1.
- `pending` counts reads issued but not yet written to the FIFO (0..2). A 2-stage valid shift register tracks it: stage 1 is the BRAM address latch, stage 2 is `bram_dout` holding the data.
- FIFO write occurs when stage 2 is valid. `bram_dout` is sampled only then. The BRAM holds its output when disabled, and that value is ignored.
- The FIFO stores {last, data}. `last` is set on the entry written for issue index = size.
- FIFO read occurs on `out_valid & out_ready`. A simultaneous push and pop in the same cycle is legal, and the count is unchanged.
- The credit rule guarantees the FIFO never overflows. Pops are not credited in the same cycle.
- Address wrap: an address of 255+1 becomes 0. There is no error.
- `cmd_valid` is ignored outside IDLE. At least one idle cycle separates commands.
- Assertion of `reset`, including mid-command, forces IDLE, empties the FIFO, clears `pending`, and discards in-flight reads.

## Timing
- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `bram_en`=0, `bram_we`=0, `bram_addr`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - `busy`=0.
- `bram_en` and `bram_addr` are combinational from state and credit.
- Pipeline from a command accepted at edge E:
  - First read issues in cycle E+1.
  - BRAM output is valid in cycle E+2.
  - FIFO write occurs at edge E+2.
  - `out_valid` is high from cycle E+3.
- Latency from command to first beat is 3 cycles.
- With `out_ready` held high, throughput is 1 beat/cycle.
- An N-beat command completes its last handshake at edge E+N+2 and returns to IDLE in the following cycle.
- `out_data` and `out_last` are stable while `out_valid` is high and `out_ready` is low.

## Structure
- The shared package holds:
  - `BRAM_ADDR_W`=8 and `BRAM_DATA_W`=128.
  - The state enum {IDLE, ISSUE, DRAIN}.
- Sub-module `stream_fifo`: a parameterised synchronous FIFO with count output, async reset, and width DATA_W+1. It is the only natural split; the FSM and credit logic stay in the top.

## Test plan
- Single-beat case: addr 0x10, size 0, `out_ready`=1. Expect exactly one `bram_en` pulse with addr 0x10, then one beat carrying mem[0x10] with `out_last`=1 three cycles after acceptance. `busy` then falls.
- Burst: addr 0x20, size 7, `out_ready`=1. Expect 8 consecutive beats mem[0x20..0x27] on consecutive cycles, with `out_last` only on the 8th.
- Wrap: addr 0xFE, size 3. Expect `bram_addr` sequence 0xFE, 0xFF, 0x00, 0x01 and data in that order.
- Back-pressure: size 15 with `out_ready` toggling 1/0 at random. Expect all 16 beats in order with no loss or duplication, FIFO count never above 4, and `bram_en` stalled while credit is exhausted.
- Reset mid-burst: assert `reset` at beat 5 of a size-31 read. Expect `out_valid`=0 and `cmd_ready`=1 immediately. A new addr 0x40, size 1 command then returns exactly mem[0x40] and mem[0x41].
- Full depth: addr 0x00, size 255. Expect 256 beats of mem[0..255], `out_last` on mem[255], and `cmd_valid` ignored while busy.
